// File: rtl/clint_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : clint_sram_slave
// Brief    : CLINT register window (msip/mtimecmp/mtime) on the data SRAM port
// Revision : 1.0 - initial release
// ============================================================================

module clint_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        MSI,
  output logic        MTI
);

  // Register offsets expressed as 8-byte word indices within the 64 KiB window
  localparam logic [12:0] C_WORD_MSIP     = 13'h0000;
  localparam logic [12:0] C_WORD_MTIMECMP = 13'h0800;
  localparam logic [12:0] C_WORD_MTIME    = 13'h17FF;
  localparam logic [15:0] C_PRESC_LAST    = 16'(TICK_DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        msip_q, msip_d;
  logic        mti_q, mti_d;

  logic        w_hit;
  logic        w_write;
  logic        w_tick;
  logic [12:0] w_word;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_time;
  logic [63:0] w_lane_mask;
  logic [63:0] w_read_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr[2:0];

  generate
    for (genvar i = 0; i < 8; i++) begin : g_lane_mask
      assign w_lane_mask[8*i +: 8] = {8{data_sram_wen[i]}};
    end
  endgenerate

  always_comb begin
    w_hit      = (data_sram_addr[31:16] == BASE_ADDR[31:16]);
    w_word     = data_sram_addr[15:3];
    w_write    = data_sram_en && w_hit && (data_sram_wen != 8'h00);
    w_sel_msip = (w_word == C_WORD_MSIP);
    w_sel_cmp  = (w_word == C_WORD_MTIMECMP);
    w_sel_time = (w_word == C_WORD_MTIME);
    w_tick     = (presc_q == C_PRESC_LAST);
  end

  // Read mux always sees pre-edge register values, giving read-first behaviour
  always_comb begin
    w_read_val = '0;
    if (w_hit) begin
      if (w_sel_msip) begin
        w_read_val = {63'b0, msip_q};
      end else if (w_sel_cmp) begin
        w_read_val = mtimecmp_q;
      end else if (w_sel_time) begin
        w_read_val = mtime_q;
      end
    end
  end

  always_comb begin
    presc_d    = w_tick ? 16'd0 : presc_q + 16'd1;
    mtime_d    = w_tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    mti_d      = (mtime_q >= mtimecmp_q);
    rdata_d    = data_sram_en ? w_read_val : rdata_q;

    // A software write to mtime overrides the tick; merge uses pre-increment value
    if (w_write && w_sel_time) begin
      mtime_d = (mtime_q & ~w_lane_mask) | (data_sram_wdata & w_lane_mask);
    end
    if (w_write && w_sel_cmp) begin
      mtimecmp_d = (mtimecmp_q & ~w_lane_mask) | (data_sram_wdata & w_lane_mask);
    end
    if (w_write && w_sel_msip && data_sram_wen[0]) begin
      msip_d = data_sram_wdata[0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mti_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mti_q      <= mti_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign MSI             = msip_q;
  assign MTI             = mti_q;

endmodule

`default_nettype wire
